reorder_arb: RTL and testbench

REORDER_ARB -- requirements
Module: reorder_arb

---
 rtl/reorder_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 36 +++
 rtl/reorder_arb.sv | 114 +++++++++++
 tb/tb_reorder_arb.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_arb_pkg.sv
// Shared widths for the two-requester read arbiter and its ID merge helper.
package reorder_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int LOCAL_ID_W = 3;
    localparam int ID_W       = 4;
    localparam int CNT_W      = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Merged downstream ID carries the requester index in its top bit.
    function automatic logic [ID_W-1:0] merge_id(input logic reqIdx,
                                                 input logic [LOCAL_ID_W-1:0] localId);
        return {reqIdx, localId};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: the favoured requester wins if eligible, else the other.
module rr_arbiter2
    import reorder_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic               i_advance,
    output logic               o_grantValid,
    output logic               o_winner
);

    logic r_rrPtr;

    always_comb begin
        o_grantValid = 1'b0;
        o_winner     = r_rrPtr;
        if (i_eligible[r_rrPtr]) begin
            o_grantValid = 1'b1;
            o_winner     = r_rrPtr;
        end else if (i_eligible[~r_rrPtr]) begin
            o_grantValid = 1'b1;
            o_winner     = ~r_rrPtr;
        end
    end

    // Priority flips to the loser only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rrPtr <= 1'b0;
        end else if (i_advance && o_grantValid) begin
            r_rrPtr <= ~o_winner;
        end
    end

endmodule

// File: rtl/reorder_arb.sv
// Merges two AXI-like read requesters onto one AR channel and routes R back by ID.
module reorder_arb
    import reorder_arb_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0][LOCAL_ID_W-1:0]  s_arid_i,
    input  logic [NUM_REQ-1:0]                  s_arvalid_i,
    output logic [NUM_REQ-1:0]                  s_arready_o,
    output logic [ID_W-1:0]                     m_arid_o,
    output logic                                m_arvalid_o,
    input  logic                                m_arready_i,
    input  logic [DATA_WIDTH-1:0]               m_rdata_i,
    input  logic [ID_W-1:0]                     m_rid_i,
    input  logic                                m_rvalid_i,
    output logic                                m_rready_o,
    output logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  s_rdata_o,
    output logic [NUM_REQ-1:0][LOCAL_ID_W-1:0]  s_rid_o,
    output logic [NUM_REQ-1:0]                  s_rvalid_o,
    input  logic [NUM_REQ-1:0]                  s_rready_i,
    output logic                                idle_o,
    output logic                                err_o
);

    localparam cnt_t MAX_CNT = cnt_t'(MAX_OUTSTANDING);

    logic                            r_arValid;
    logic [ID_W-1:0]                 r_arId;
    logic [NUM_REQ-1:0][CNT_W-1:0]   r_cnt;
    logic                            r_err;

    logic               w_loadEn;
    logic [NUM_REQ-1:0] w_eligible;
    logic               w_grantValid;
    logic               w_winner;
    logic               w_accept;
    logic               w_rSel;
    logic               w_rHs;
    logic [NUM_REQ-1:0] w_inc;
    logic [NUM_REQ-1:0] w_dec;

    assign w_loadEn = ~r_arValid | m_arready_i;

    always_comb begin
        w_eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_eligible[i] = s_arvalid_i[i] & (r_cnt[i] < MAX_CNT);
        end
    end

    rr_arbiter2 u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_eligible   (w_eligible),
        .i_advance    (w_loadEn),
        .o_grantValid (w_grantValid),
        .o_winner     (w_winner)
    );

    assign w_accept    = w_loadEn & w_grantValid;
    assign w_inc       = w_accept ? (w_winner ? 2'b10 : 2'b01) : 2'b00;
    assign s_arready_o = w_inc;

    // Single AR holding register; it only reloads when empty or being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arValid <= 1'b0;
            r_arId    <= '0;
        end else if (w_loadEn) begin
            r_arValid <= w_grantValid;
            if (w_grantValid) begin
                r_arId <= merge_id(w_winner, s_arid_i[w_winner]);
            end
        end
    end

    assign m_arvalid_o = r_arValid;
    assign m_arid_o    = r_arId;

    assign w_rSel      = m_rid_i[ID_W-1];
    assign s_rvalid_o  = w_rSel ? {m_rvalid_i, 1'b0} : {1'b0, m_rvalid_i};
    assign s_rdata_o   = {m_rdata_i, m_rdata_i};
    assign s_rid_o     = {m_rid_i[LOCAL_ID_W-1:0], m_rid_i[LOCAL_ID_W-1:0]};
    assign m_rready_o  = s_rready_i[w_rSel];
    assign w_rHs       = m_rvalid_i & m_rready_o;
    assign w_dec       = w_rHs ? (w_rSel ? 2'b10 : 2'b01) : 2'b00;

    // A response with nothing outstanding is a protocol error; the count stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    if (r_cnt[i] == '0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt[i] <= r_cnt[i] - 1'b1;
                    end
                end
            end
        end
    end

    assign err_o  = r_err;
    assign idle_o = ~r_arValid & (r_cnt[0] == '0) & (r_cnt[1] == '0);

endmodule

// File: tb/tb_reorder_arb.sv
// Self-checking bench for reorder_arb: routing table, directed corner cases, random vs reference model.
module tb_reorder_arb;

    localparam int DW      = 8;
    localparam int MAX_OUT = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0][2:0]     s_arid_i;
    logic [1:0]          s_arvalid_i;
    logic [1:0]          s_arready_o;
    logic [3:0]          m_arid_o;
    logic                m_arvalid_o;
    logic                m_arready_i;
    logic [DW-1:0]       m_rdata_i;
    logic [3:0]          m_rid_i;
    logic                m_rvalid_i;
    logic                m_rready_o;
    logic [1:0][DW-1:0]  s_rdata_o;
    logic [1:0][2:0]     s_rid_o;
    logic [1:0]          s_rvalid_o;
    logic [1:0]          s_rready_i;
    logic                idle_o;
    logic                err_o;

    int checksRun    = 0;
    int checksPassed = 0;

    typedef struct {
        logic [3:0]    rid;
        logic          rvalid;
        logic [1:0]    rready;
        logic [DW-1:0] rdata;
        logic [1:0]    expRvalid;
        logic          expMready;
        logic [2:0]    expRid;
    } rVec_t;

    rVec_t vecs [6];

    // Reference model state, described as a pending-request slot plus per-requester tallies.
    int slotFull;
    int slotId;
    int favored;
    int outstanding [2];
    int errSeen;

    reorder_arb #(.DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_arid_i    (s_arid_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .m_arid_o    (m_arid_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rid_i     (m_rid_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rready_o  (m_rready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rid_o     (s_rid_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .idle_o      (idle_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checksRun++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clearInputs();
        s_arid_i    = '0;
        s_arvalid_i = '0;
        m_arready_i = 1'b0;
        m_rdata_i   = '0;
        m_rid_i     = '0;
        m_rvalid_i  = 1'b0;
        s_rready_i  = '0;
    endtask

    task automatic applyReset();
        clearInputs();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        settle();
    endtask

    task automatic applyStimulus();
        logic [1:0] expAr;
        logic [1:0] expRv;
        int         grantee;
        int         canLoad;
        int         k;
        int         inc [2];
        int         dec [2];

        applyReset();
        slotFull = 0; slotId = 0; favored = 0; errSeen = 0;
        outstanding[0] = 0; outstanding[1] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            s_arvalid_i[0] = ($urandom_range(0, 3) != 0);
            s_arvalid_i[1] = ($urandom_range(0, 3) != 0);
            s_arid_i[0]    = 3'($urandom_range(0, 7));
            s_arid_i[1]    = 3'($urandom_range(0, 7));
            m_arready_i    = ($urandom_range(0, 9) < 7);
            k              = $urandom_range(0, 1);
            m_rid_i        = {1'(k), 3'($urandom_range(0, 7))};
            m_rvalid_i     = (outstanding[k] > 0) && ($urandom_range(0, 1) == 1);
            s_rready_i     = 2'($urandom_range(0, 3));
            m_rdata_i      = DW'($urandom);
            settle();

            canLoad = (slotFull == 0) || m_arready_i;
            grantee = -1;
            if (s_arvalid_i[favored] && outstanding[favored] < MAX_OUT) grantee = favored;
            else if (s_arvalid_i[1-favored] && outstanding[1-favored] < MAX_OUT) grantee = 1 - favored;
            expAr = (canLoad != 0 && grantee >= 0) ? 2'(1 << grantee) : 2'b00;
            expRv = m_rvalid_i ? 2'(1 << k) : 2'b00;

            checkOutput("rnd_arready", 32'(s_arready_o), 32'(expAr));
            checkOutput("rnd_arvalid", 32'(m_arvalid_o), 32'(slotFull));
            if (slotFull != 0) checkOutput("rnd_arid", 32'(m_arid_o), 32'(slotId));
            checkOutput("rnd_rvalid", 32'(s_rvalid_o), 32'(expRv));
            checkOutput("rnd_rready", 32'(m_rready_o), 32'(s_rready_i[k]));
            checkOutput("rnd_idle", 32'(idle_o),
                        32'((slotFull == 0 && outstanding[0] == 0 && outstanding[1] == 0) ? 1 : 0));
            checkOutput("rnd_err", 32'(err_o), 32'(errSeen));

            inc[0] = 0; inc[1] = 0; dec[0] = 0; dec[1] = 0;
            if (canLoad != 0) begin
                if (grantee >= 0) begin
                    slotFull     = 1;
                    slotId       = grantee * 8 + int'(s_arid_i[grantee]);
                    favored      = 1 - grantee;
                    inc[grantee] = 1;
                end else begin
                    slotFull = 0;
                end
            end
            if (m_rvalid_i && s_rready_i[k]) dec[k] = 1;
            for (int r = 0; r < 2; r++) begin
                if (inc[r] - dec[r] < 0 && outstanding[r] == 0) errSeen = 1;
                else outstanding[r] = outstanding[r] + inc[r] - dec[r];
            end
            tick();
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;

        vecs[0] = '{4'hA, 1'b1, 2'b01, 8'h5A, 2'b10, 1'b0, 3'd2};
        vecs[1] = '{4'hA, 1'b1, 2'b11, 8'hA5, 2'b10, 1'b1, 3'd2};
        vecs[2] = '{4'h3, 1'b1, 2'b01, 8'h01, 2'b01, 1'b1, 3'd3};
        vecs[3] = '{4'h7, 1'b1, 2'b10, 8'hFF, 2'b01, 1'b0, 3'd7};
        vecs[4] = '{4'hC, 1'b0, 2'b10, 8'h3C, 2'b00, 1'b1, 3'd4};
        vecs[5] = '{4'h0, 1'b0, 2'b00, 8'h00, 2'b00, 1'b0, 3'd0};

        // R routing is purely combinational, so the table is applied while held in reset.
        repeat (2) tick();
        for (int i = 0; i < 6; i++) begin
            m_rid_i    = vecs[i].rid;
            m_rvalid_i = vecs[i].rvalid;
            s_rready_i = vecs[i].rready;
            m_rdata_i  = vecs[i].rdata;
            settle();
            checkOutput("tbl_rvalid", 32'(s_rvalid_o), 32'(vecs[i].expRvalid));
            checkOutput("tbl_mready", 32'(m_rready_o), 32'(vecs[i].expMready));
            checkOutput("tbl_rid0", 32'(s_rid_o[0]), 32'(vecs[i].expRid));
            checkOutput("tbl_rid1", 32'(s_rid_o[1]), 32'(vecs[i].expRid));
            checkOutput("tbl_rdata0", 32'(s_rdata_o[0]), 32'(vecs[i].rdata));
            checkOutput("tbl_rdata1", 32'(s_rdata_o[1]), 32'(vecs[i].rdata));
        end

        // Both requesters from reset: requester 0 first, then strict alternation.
        applyReset();
        checkOutput("rst_arvalid", 32'(m_arvalid_o), 32'(0));
        checkOutput("rst_arid", 32'(m_arid_o), 32'(0));
        checkOutput("rst_idle", 32'(idle_o), 32'(1));
        checkOutput("rst_err", 32'(err_o), 32'(0));
        s_arvalid_i = 2'b11; s_arid_i[0] = 3'd3; s_arid_i[1] = 3'd5; m_arready_i = 1'b1;
        settle();
        checkOutput("both_ready0", 32'(s_arready_o), 32'(2'b01));
        tick();
        checkOutput("both_arvalid", 32'(m_arvalid_o), 32'(1));
        checkOutput("both_arid0", 32'(m_arid_o), 32'(4'h3));
        checkOutput("both_ready1", 32'(s_arready_o), 32'(2'b10));
        tick();
        checkOutput("both_arid1", 32'(m_arid_o), 32'(4'hD));
        s_arvalid_i = 2'b00;
        tick();
        checkOutput("both_drain", 32'(m_arvalid_o), 32'(0));
        checkOutput("both_notidle", 32'(idle_o), 32'(0));

        // Downstream stall holds the AR register and refuses new requests.
        applyReset();
        s_arvalid_i = 2'b01; s_arid_i[0] = 3'd2;
        settle();
        checkOutput("stall_first", 32'(s_arready_o), 32'(2'b01));
        tick();
        s_arvalid_i = 2'b11; s_arid_i[0] = 3'd6; s_arid_i[1] = 3'd7;
        for (int i = 0; i < 4; i++) begin
            settle();
            checkOutput("stall_arvalid", 32'(m_arvalid_o), 32'(1));
            checkOutput("stall_arid", 32'(m_arid_o), 32'(4'h2));
            checkOutput("stall_ready", 32'(s_arready_o), 32'(2'b00));
            tick();
        end
        m_arready_i = 1'b1;
        settle();
        checkOutput("stall_release", 32'(s_arready_o), 32'(2'b10));
        tick();
        checkOutput("stall_next", 32'(m_arid_o), 32'(4'hF));

        // Outstanding limit blocks only the saturated requester.
        applyReset();
        m_arready_i = 1'b1; s_arvalid_i = 2'b10; s_arid_i[1] = 3'd1;
        for (int i = 0; i < MAX_OUT; i++) begin
            settle();
            checkOutput("lim_accept", 32'(s_arready_o), 32'(2'b10));
            tick();
        end
        settle();
        checkOutput("lim_block", 32'(s_arready_o), 32'(2'b00));
        tick();
        checkOutput("lim_block2", 32'(s_arready_o), 32'(2'b00));
        s_arvalid_i = 2'b11; s_arid_i[0] = 3'd4;
        settle();
        checkOutput("lim_other", 32'(s_arready_o), 32'(2'b01));
        tick();
        checkOutput("lim_other_id", 32'(m_arid_o), 32'(4'h4));
        s_arvalid_i = 2'b10; m_rid_i = 4'h9; m_rvalid_i = 1'b1; s_rready_i = 2'b10;
        settle();
        checkOutput("lim_rready", 32'(m_rready_o), 32'(1));
        checkOutput("lim_rvalid", 32'(s_rvalid_o), 32'(2'b10));
        checkOutput("lim_still", 32'(s_arready_o), 32'(2'b00));
        tick();
        m_rvalid_i = 1'b0;
        settle();
        checkOutput("lim_unblock", 32'(s_arready_o), 32'(2'b10));

        // Response waits on the addressed requester's ready only.
        applyReset();
        s_arvalid_i = 2'b10; s_arid_i[1] = 3'd2; m_arready_i = 1'b1;
        tick();
        s_arvalid_i = 2'b00; m_rid_i = 4'hA; m_rvalid_i = 1'b1; s_rready_i = 2'b01; m_rdata_i = 8'hC3;
        for (int i = 0; i < 2; i++) begin
            settle();
            checkOutput("route_rvalid", 32'(s_rvalid_o), 32'(2'b10));
            checkOutput("route_rid1", 32'(s_rid_o[1]), 32'(3'd2));
            checkOutput("route_mready", 32'(m_rready_o), 32'(0));
            checkOutput("route_data", 32'(s_rdata_o[1]), 32'(8'hC3));
            tick();
        end
        checkOutput("route_busy", 32'(idle_o), 32'(0));
        s_rready_i = 2'b11;
        settle();
        checkOutput("route_mready_on", 32'(m_rready_o), 32'(1));
        tick();
        m_rvalid_i = 1'b0;
        settle();
        checkOutput("route_idle", 32'(idle_o), 32'(1));
        checkOutput("route_noerr", 32'(err_o), 32'(0));

        // Spurious response sets a sticky error cleared only by reset.
        applyReset();
        m_rid_i = 4'h1; m_rvalid_i = 1'b1; s_rready_i = 2'b01;
        settle();
        checkOutput("err_before", 32'(err_o), 32'(0));
        tick();
        m_rvalid_i = 1'b0;
        checkOutput("err_set", 32'(err_o), 32'(1));
        checkOutput("err_idle", 32'(idle_o), 32'(1));
        repeat (3) tick();
        checkOutput("err_sticky", 32'(err_o), 32'(1));
        rst_n = 1'b0;
        settle();
        checkOutput("err_cleared", 32'(err_o), 32'(0));

        // Asynchronous reset mid-cycle with traffic in flight.
        applyReset();
        s_arvalid_i = 2'b01; s_arid_i[0] = 3'd5; m_arready_i = 1'b1;
        repeat (3) tick();
        m_arready_i = 1'b0; s_arvalid_i = 2'b00;
        settle();
        checkOutput("arst_busy", 32'(idle_o), 32'(0));
        checkOutput("arst_held", 32'(m_arvalid_o), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_arvalid", 32'(m_arvalid_o), 32'(0));
        checkOutput("arst_arid", 32'(m_arid_o), 32'(0));
        checkOutput("arst_idle", 32'(idle_o), 32'(1));
        checkOutput("arst_err", 32'(err_o), 32'(0));

        applyStimulus();

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
